// File: rtl/vga_console_write_ctrl.sv
// Write-port sequencer for the VGA text-console character buffer.
// Round-robin arbitration between character requesters, cursor ownership,
// newline/form-feed handling and full-screen clears, optionally gated to vblank.
module vga_console_write_ctrl #(
    parameter int unsigned N_REQ       = 2,
    parameter int unsigned COLS        = 30,
    parameter int unsigned ROWS        = 30,
    parameter int unsigned ADDR_W      = 10,
    parameter bit          VBLANK_ONLY = 1'b0,
    parameter logic [7:0]  CLEAR_CHAR  = 8'h20
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic [N_REQ-1:0]     req_valid,
    input  logic [8*N_REQ-1:0]   req_char,
    output logic [N_REQ-1:0]     req_ready,
    input  logic                 clear_req,
    input  logic                 vblank,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [7:0]           ram_wdata,
    output logic [ADDR_W-1:0]    cursor,
    output logic                 busy
);

    localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [PTR_W:0]    NREQ_W    = (PTR_W+1)'(N_REQ);
    localparam logic [ADDR_W:0]   COLS_W    = (ADDR_W+1)'(COLS);
    localparam logic [ADDR_W:0]   CELLS_W   = (ADDR_W+1)'(COLS * ROWS);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(COLS * ROWS - 1);

    localparam logic [7:0] CHAR_NL = 8'h0A;
    localparam logic [7:0] CHAR_FF = 8'h0C;

    typedef enum logic [1:0] {
        StIdle,
        StWrite,
        StClear
    } state_e;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  cursor_q, cursor_d;
    logic [ADDR_W-1:0]  clr_addr_q, clr_addr_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [7:0]         char_q, char_d;
    logic               ram_we_q, ram_we_d;
    logic [ADDR_W-1:0]  ram_addr_q, ram_addr_d;
    logic [7:0]         ram_wdata_q, ram_wdata_d;

    logic               wr_ok;
    logic               grant_vld;
    logic [PTR_W-1:0]   grant_idx;
    logic [PTR_W:0]     search_sum;
    logic [PTR_W-1:0]   search_idx;
    logic [PTR_W:0]     rr_sum;
    logic [PTR_W-1:0]   rr_next;

    logic [ADDR_W:0]    cur_ext;
    logic [ADDR_W:0]    col_ext;
    logic [ADDR_W:0]    nl_ext;
    logic [ADDR_W:0]    inc_ext;
    logic [ADDR_W-1:0]  cursor_nl;
    logic [ADDR_W-1:0]  cursor_inc;

    assign wr_ok = VBLANK_ONLY ? vblank : 1'b1;

    // Cursor arithmetic: start of next row and next cell, both wrapping to cell 0.
    assign cur_ext    = {1'b0, cursor_q};
    assign col_ext    = cur_ext % COLS_W;
    assign nl_ext     = cur_ext - col_ext + COLS_W;
    assign inc_ext    = cur_ext + 1'b1;
    assign cursor_nl  = (nl_ext >= CELLS_W) ? '0 : nl_ext[ADDR_W-1:0];
    assign cursor_inc = (inc_ext >= CELLS_W) ? '0 : inc_ext[ADDR_W-1:0];

    // Round-robin search from rr_ptr upward; only offered in IDLE with no pending clear.
    always_comb begin
        grant_vld  = 1'b0;
        grant_idx  = '0;
        search_sum = '0;
        search_idx = '0;
        req_ready  = '0;
        if (!HRESET && state_q == StIdle && !clear_req && wr_ok) begin
            for (int unsigned k = 0; k < N_REQ; k++) begin
                search_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
                if (search_sum >= NREQ_W) begin
                    search_sum = search_sum - NREQ_W;
                end
                search_idx = search_sum[PTR_W-1:0];
                if (!grant_vld && req_valid[search_idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = search_idx;
                end
            end
            if (grant_vld) begin
                req_ready[grant_idx] = 1'b1;
            end
        end
    end

    // Pointer following the granted requester, modulo N_REQ.
    always_comb begin
        rr_sum  = {1'b0, grant_idx} + 1'b1;
        rr_next = (rr_sum >= NREQ_W) ? '0 : rr_sum[PTR_W-1:0];
    end

    // Next-state and registered buffer-write outputs.
    always_comb begin
        state_d     = state_q;
        cursor_d    = cursor_q;
        clr_addr_d  = clr_addr_q;
        rr_ptr_d    = rr_ptr_q;
        char_d      = char_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;

        unique case (state_q)
            StIdle: begin
                if (clear_req) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end else if (grant_vld) begin
                    char_d   = req_char[{grant_idx, 3'b000} +: 8];
                    rr_ptr_d = rr_next;
                    state_d  = StWrite;
                end
            end
            StWrite: begin
                state_d = StIdle;
                if (char_q == CHAR_NL) begin
                    cursor_d = cursor_nl;
                end else if (char_q == CHAR_FF) begin
                    state_d    = StClear;
                    clr_addr_d = '0;
                end else begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = cursor_q;
                    ram_wdata_d = char_q;
                    cursor_d    = cursor_inc;
                end
            end
            StClear: begin
                if (wr_ok) begin
                    ram_we_d    = 1'b1;
                    ram_addr_d  = clr_addr_q;
                    ram_wdata_d = CLEAR_CHAR;
                    if (clr_addr_q == LAST_CELL) begin
                        cursor_d = '0;
                        state_d  = StIdle;
                    end else begin
                        clr_addr_d = clr_addr_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= StIdle;
            cursor_q    <= '0;
            clr_addr_q  <= '0;
            rr_ptr_q    <= '0;
            char_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            cursor_q    <= cursor_d;
            clr_addr_q  <= clr_addr_d;
            rr_ptr_q    <= rr_ptr_d;
            char_q      <= char_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign cursor    = cursor_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_vga_console_write_ctrl.sv
// Bench for vga_console_write_ctrl: two instances (VBLANK_ONLY 0 and 1) share the
// stimulus; an integer-level model of the console is checked every cycle.
module tb_vga_console_write_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [15:0] req_char;
    logic        clear_req;
    logic        vblank;

    logic [1:0]  rdy  [2];
    logic        we   [2];
    logic [9:0]  addr [2];
    logic [7:0]  wd   [2];
    logic [9:0]  cur  [2];
    logic        bsy  [2];

    int tests = 0;
    int fails = 0;
    bit cmp_en = 1'b0;

    // Model state per instance: cursor cell, rr pointer, clear progress (-1 none),
    // pending accepted character (-1 none), registered write outputs.
    int m_cur [2], m_rr [2], m_clr [2], m_pend [2], m_we [2], m_addr [2], m_wd [2];

    always #5 clk = ~clk;

    vga_console_write_ctrl #(.VBLANK_ONLY(1'b0)) dut0 (
        .HCLK(clk), .HRESET(rst), .req_valid(req_valid), .req_char(req_char),
        .req_ready(rdy[0]), .clear_req(clear_req), .vblank(vblank), .ram_we(we[0]),
        .ram_addr(addr[0]), .ram_wdata(wd[0]), .cursor(cur[0]), .busy(bsy[0])
    );

    vga_console_write_ctrl #(.VBLANK_ONLY(1'b1)) dut1 (
        .HCLK(clk), .HRESET(rst), .req_valid(req_valid), .req_char(req_char),
        .req_ready(rdy[1]), .clear_req(clear_req), .vblank(vblank), .ram_we(we[1]),
        .ram_addr(addr[1]), .ram_wdata(wd[1]), .cursor(cur[1]), .busy(bsy[1])
    );

    task automatic check(input string nm, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [dut%0d] at %0t: got %0h, expected %0h", nm, k, $time, act, exp);
        end
    endtask

    // Requester the model grants this cycle, or -1.
    function automatic int m_grant(input int k);
        if (rst || m_pend[k] >= 0 || m_clr[k] >= 0 || clear_req) return -1;
        if (k == 1 && !vblank) return -1;
        for (int j = 0; j < 2; j++) begin
            int g;
            g = (m_rr[k] + j) % 2;
            if (req_valid[g]) return g;
        end
        return -1;
    endfunction

    task automatic m_step();
        for (int k = 0; k < 2; k++) begin
            int g;
            g = m_grant(k);
            if (rst) begin
                m_cur[k] = 0; m_rr[k] = 0; m_clr[k] = -1; m_pend[k] = -1;
                m_we[k] = 0; m_addr[k] = 0; m_wd[k] = 0;
            end else begin
                m_we[k] = 0;
                if (m_pend[k] >= 0) begin
                    if (m_pend[k] == 10) begin
                        m_cur[k] = ((m_cur[k] / 30 + 1) % 30) * 30;
                    end else if (m_pend[k] == 12) begin
                        m_clr[k] = 0;
                    end else begin
                        m_we[k] = 1; m_addr[k] = m_cur[k]; m_wd[k] = m_pend[k];
                        m_cur[k] = (m_cur[k] + 1) % 900;
                    end
                    m_pend[k] = -1;
                end else if (m_clr[k] >= 0) begin
                    if (k == 0 || vblank) begin
                        m_we[k] = 1; m_addr[k] = m_clr[k]; m_wd[k] = 32;
                        if (m_clr[k] == 899) begin
                            m_clr[k] = -1; m_cur[k] = 0;
                        end else begin
                            m_clr[k]++;
                        end
                    end
                end else if (clear_req) begin
                    m_clr[k] = 0;
                end else if (g >= 0) begin
                    m_pend[k] = int'(req_char[g*8 +: 8]);
                    m_rr[k] = (g + 1) % 2;
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            int g;
            g = m_grant(k);
            check("req_ready", k, 32'(rdy[k]), (g < 0) ? 32'd0 : (32'd1 << g));
            check("ram_we", k, 32'(we[k]), 32'(m_we[k]));
            if (m_we[k] != 0) begin
                check("ram_addr", k, 32'(addr[k]), 32'(m_addr[k]));
                check("ram_wdata", k, 32'(wd[k]), 32'(m_wd[k]));
            end
            check("cursor", k, 32'(cur[k]), 32'(m_cur[k]));
            check("busy", k, 32'(bsy[k]), (m_pend[k] >= 0 || m_clr[k] >= 0) ? 32'd1 : 32'd0);
        end
    endtask

    always @(posedge clk) m_step();
    always @(negedge clk) if (cmp_en) compare_all();

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Offer one character and wait (bounded) for dut0 to grant it; returns one cycle
    // after the accept edge, when the write/cursor update is visible.
    task automatic send(input int who, input logic [7:0] ch);
        bit ok;
        ok = 1'b0;
        req_char[who*8 +: 8] = ch;
        req_valid[who] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rdy[0][who]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid[who] = 1'b0;
        check("send_granted", 0, 32'(ok), 32'd1);
        tick(1);
    endtask

    initial begin
        int grants[$];
        int cnt;
        bit done;

        rst = 1'b1; req_valid = '0; req_char = '0; clear_req = 1'b0; vblank = 1'b1;
        @(posedge clk);
        #1;
        cmp_en = 1'b1;
        tick(1);
        check("reset_cursor", 0, 32'(cur[0]), 32'd0);
        check("reset_busy", 1, 32'(bsy[1]), 32'd0);
        rst = 1'b0;

        // First character lands at cell 0.
        send(0, 8'h41);
        check("A_we", 0, 32'(we[0]), 32'd1);
        check("A_addr", 0, 32'(addr[0]), 32'd0);
        check("A_wdata", 0, 32'(wd[0]), 32'h41);
        check("A_cursor", 0, 32'(cur[0]), 32'd1);

        // Both requesters continuously valid from rr_ptr=0.
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req_char = {8'h62, 8'h61};
        req_valid = 2'b11;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (rdy[0] != 2'b00) grants.push_back(int'(rdy[0]));
        end
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        check("rr_count", 0, 32'(grants.size()), 32'd4);
        if (grants.size() == 4) begin
            check("rr_g0", 0, 32'(grants[0]), 32'd1);
            check("rr_g1", 0, 32'(grants[1]), 32'd2);
            check("rr_g2", 0, 32'(grants[2]), 32'd1);
            check("rr_g3", 0, 32'(grants[3]), 32'd2);
        end
        check("rr_cursor", 0, 32'(cur[0]), 32'd4);

        // Newline behaviour, including the last-row wrap.
        send(0, 8'h78);
        check("pre_nl_cursor", 0, 32'(cur[0]), 32'd5);
        send(0, 8'h0A);
        check("nl_cursor", 0, 32'(cur[0]), 32'd30);
        repeat (28) send(0, 8'h0A);
        check("nl_row29", 0, 32'(cur[0]), 32'd870);
        repeat (25) send(1, 8'h79);
        check("cursor_895", 0, 32'(cur[0]), 32'd895);
        send(0, 8'h0A);
        check("nl_wrap", 0, 32'(cur[0]), 32'd0);

        // Writing the last cell wraps the cursor.
        repeat (29) send(0, 8'h0A);
        repeat (29) send(1, 8'h79);
        check("cursor_899", 0, 32'(cur[0]), 32'd899);
        send(0, 8'h5A);
        check("Z_we", 0, 32'(we[0]), 32'd1);
        check("Z_addr", 0, 32'(addr[0]), 32'd899);
        check("Z_wdata", 0, 32'(wd[0]), 32'h5A);
        check("Z_cursor", 0, 32'(cur[0]), 32'd0);

        // Clear beats a same-cycle request; 900 fill writes, then the request is served.
        req_char[7:0] = 8'h51;
        req_valid = 2'b01;
        clear_req = 1'b1;
        @(negedge clk);
        check("clr_no_grant", 0, 32'(rdy[0]), 32'd0);
        @(posedge clk);
        #1;
        clear_req = 1'b0;
        cnt = 0;
        done = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (we[0] && wd[0] == 8'h20 && addr[0] == 10'(cnt)) cnt++;
            if (!bsy[0]) begin
                done = 1'b1;
                break;
            end
        end
        check("clr_done", 0, 32'(done), 32'd1);
        check("clr_writes", 0, 32'(cnt), 32'd900);
        check("clr_cursor", 0, 32'(cur[0]), 32'd0);
        check("clr_then_grant", 0, 32'(rdy[0]), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        tick(1);
        check("post_clr_addr", 0, 32'(addr[0]), 32'd0);
        check("post_clr_wdata", 0, 32'(wd[0]), 32'h51);

        // Vblank gating: dut1 holds the request until vblank returns.
        vblank = 1'b0;
        req_char[7:0] = 8'h56;
        req_valid = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("vb_no_grant", 1, 32'(rdy[1]), 32'd0);
        end
        @(posedge clk);
        #1;
        vblank = 1'b1;
        @(negedge clk);
        check("vb_grant", 1, 32'(rdy[1]), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        tick(2);

        // Clear in dut1 stalls while vblank is low, resumes when high, aborts on reset.
        vblank = 1'b0;
        clear_req = 1'b1;
        tick(1);
        clear_req = 1'b0;
        tick(4);
        check("clr_stall_we", 1, 32'(we[1]), 32'd0);
        check("clr_stall_busy", 1, 32'(bsy[1]), 32'd1);
        vblank = 1'b1;
        tick(10);
        vblank = 1'b0;
        tick(5);
        check("clr_stall2_we", 1, 32'(we[1]), 32'd0);
        vblank = 1'b1;
        tick(10);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("rst_abort_we", 1, 32'(we[1]), 32'd0);
        check("rst_abort_busy", 1, 32'(bsy[1]), 32'd0);
        check("rst_abort_cursor", 1, 32'(cur[1]), 32'd0);
        tick(3);

        cmp_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

endmodule
